// File: rtl/yarvi_bus_arbiter.sv
// Two-master round-robin arbiter onto one in-order slave port.
// A small tag FIFO steers each read response back to its issuer.
module yarvi_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    output logic                               m0_req_ready,
    input  logic                               m0_req_read,
    input  logic                               m0_req_write,
    input  logic [ADDR_W-1:0]                  m0_req_address,
    input  logic [DATA_W-1:0]                  m0_req_data,
    output logic                               m0_res_valid,
    output logic [DATA_W-1:0]                  m0_res_data,
    output logic                               m1_req_ready,
    input  logic                               m1_req_read,
    input  logic                               m1_req_write,
    input  logic [ADDR_W-1:0]                  m1_req_address,
    input  logic [DATA_W-1:0]                  m1_req_data,
    output logic                               m1_res_valid,
    output logic [DATA_W-1:0]                  m1_res_data,
    input  logic                               s_req_ready,
    output logic                               s_req_read,
    output logic                               s_req_write,
    output logic [ADDR_W-1:0]                  s_req_address,
    output logic [DATA_W-1:0]                  s_req_data,
    input  logic                               s_res_valid,
    input  logic [DATA_W-1:0]                  s_res_data,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_orphan
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUTSTANDING);

    logic                       r_last_grant;
    logic [MAX_OUTSTANDING-1:0] r_tags;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic                       r_err_orphan;

    logic w_full;
    logic w_empty;
    logic w_elig0;
    logic w_elig1;
    logic w_gnt0;
    logic w_gnt1;
    logic w_push;
    logic w_pop;
    logic w_orphan;
    logic w_head;

    // Eligibility uses the registered count, so a pop frees a slot next cycle.
    assign w_full   = (r_count == FULL);
    assign w_empty  = (r_count == '0);
    assign w_elig0  = !reset && s_req_ready &&
                      (m0_req_write || (m0_req_read && !w_full));
    assign w_elig1  = !reset && s_req_ready &&
                      (m1_req_write || (m1_req_read && !w_full));
    assign w_gnt0   = w_elig0 && (!w_elig1 || r_last_grant);
    assign w_gnt1   = w_elig1 && !w_gnt0;

    assign w_push   = (w_gnt0 && m0_req_read) || (w_gnt1 && m1_req_read);
    assign w_head   = r_tags[r_rd_ptr];
    assign w_pop    = !reset && s_res_valid && !w_empty;
    assign w_orphan = s_res_valid && w_empty;

    assign m0_req_ready = w_gnt0;
    assign m1_req_ready = w_gnt1;
    assign m0_res_valid = w_pop && !w_head;
    assign m1_res_valid = w_pop && w_head;
    assign m0_res_data  = s_res_data;
    assign m1_res_data  = s_res_data;
    assign outstanding  = r_count;
    assign err_orphan   = r_err_orphan;

    always_comb begin
        s_req_read    = 1'b0;
        s_req_write   = 1'b0;
        s_req_address = '0;
        s_req_data    = '0;
        unique case (1'b1)
            w_gnt0: begin
                s_req_read    = m0_req_read;
                s_req_write   = m0_req_write;
                s_req_address = m0_req_address;
                s_req_data    = m0_req_data;
            end
            w_gnt1: begin
                s_req_read    = m1_req_read;
                s_req_write   = m1_req_write;
                s_req_address = m1_req_address;
                s_req_data    = m1_req_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_tags       <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_gnt0 || w_gnt1)
                r_last_grant <= w_gnt1;
            if (w_push) begin
                r_tags[r_wr_ptr] <= w_gnt1;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_orphan)
                r_err_orphan <= 1'b1;
        end
    end

endmodule
